hs_ssl: RTL and testbench

- Pipelined 32-bit MIPS shift unit serving the ALU's shift instructions: SLL, SRL, SRA, ROTR, plus the variable-amount forms SLLV, SRLV, SRAV and ROTRV.
- Implemented as a two-stage logarithmic barrel shifter.
  - Stage 1 applies shift bits [4:3], i.e. by 0, 8, 16 or 24.
  - Stage 2 applies shift bits [2:0], i.e. by 0 to 7.
- Accepts one operation per cycle and delivers a registered result 2 cycles later, with a valid flag and a zero flag.

---
 rtl/hs_ssl.sv | 96 +++++++++
 tb/tb_hs_ssl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_ssl.sv
// Two-stage pipelined 32-bit MIPS barrel shifter for SLL/SRL/SRA/ROTR and their variable forms.
// Stage 1 shifts by sa[4:3]*8, stage 2 by sa[2:0]; the result is registered with valid and zero.
module hs_ssl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SAW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic             shamt_var,
    input  logic [SAW-1:0]   shamt,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpRotr = 2'b01;
    localparam logic [1:0] OpSrl  = 2'b10;
    localparam logic [1:0] OpSra  = 2'b11;

    // SRA fills from d[WIDTH-1]; after stage 1 that bit still equals the original rt[31].
    function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] d,
                                                  input logic [SAW-1:0]   amt,
                                                  input logic [1:0]       o);
        logic [2*WIDTH-1:0] rot;
        logic [WIDTH-1:0]   sh;
        rot = {d, d} >> amt;
        sh  = '0;
        unique case (o)
            OpSll:   sh = d << amt;
            OpRotr:  sh = rot[WIDTH-1:0];
            OpSrl:   sh = d >> amt;
            OpSra:   sh = $signed(d) >>> amt;
            default: sh = d;
        endcase
        return sh;
    endfunction

    logic [SAW-1:0]   sa;
    logic [SAW-1:0]   amt1;
    logic [SAW-1:0]   amt2;
    logic [WIDTH-1:0] s1_data_d;
    logic [WIDTH-1:0] res_d;

    logic             s1_valid_q;
    logic [1:0]       s1_op_q;
    logic [2:0]       s1_sa_lo_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic unused_rs;
    assign unused_rs = ^rs[WIDTH-1:SAW];

    always_comb begin
        sa        = shamt_var ? rs[SAW-1:0] : shamt;
        amt1      = {sa[SAW-1:3], 3'b000};
        amt2      = {{(SAW-3){1'b0}}, s1_sa_lo_q};
        s1_data_d = shift_fn(rt, amt1, op);
        res_d     = shift_fn(s1_data_q, amt2, s1_op_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_sa_lo_q  <= 3'b000;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_op_q    <= op;
                s1_sa_lo_q <= sa[2:0];
                s1_data_q  <= s1_data_d;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= res_d;
            end
            zero_q <= s1_valid_q && (res_d == '0);
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_hs_ssl.sv
// Scoreboard bench for hs_ssl: directed cases plus randomized ops against a bitwise reference.
module tb_hs_ssl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic        shamt_var;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    hs_ssl #(.WIDTH(32), .SAW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .shamt_var (shamt_var),
        .shamt     (shamt),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          cyc;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_id   = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: each result bit picked from rt by index arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input int sa, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            case (o)
                2'b00:   r[i] = (i >= sa) ? d[i-sa] : 1'b0;
                2'b10:   r[i] = (i + sa < 32) ? d[i+sa] : 1'b0;
                2'b11:   r[i] = (i + sa < 32) ? d[i+sa] : d[31];
                default: r[i] = d[(i+sa)%32];
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic [1:0] o, input logic v, input logic [4:0] sh,
                         input logic [31:0] s, input logic [31:0] t, input logic [31:0] exp_res,
                         input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op        = o;
        shamt_var = v;
        shamt     = sh;
        rs        = s;
        rt        = t;
        if (push) begin
            e.res = exp_res;
            e.z   = (exp_res == 32'h0);
            e.cyc = cyc + 2;
            e.id  = n_id;
            n_id++;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_model(input logic [1:0] o, input logic v, input logic [4:0] sh,
                               input logic [31:0] s, input logic [31:0] t);
        int sa;
        sa = v ? int'(s[4:0]) : int'(sh);
        drive(o, v, sh, s, t, model(o, sa, t), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rt       = $urandom;
            rs       = $urandom;
        end
    endtask

    task automatic check_rst_state(input string name);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%b result=%h zero=%b, want valid=0 result=00000000 zero=0",
                     name, out_valid, result, zero);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got result=%h at cycle %0d, want no output",
                             result, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (result !== e.res || zero !== e.z || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL op%0d: got result=%h zero=%b cycle=%0d, want %h zero=%b cycle=%0d",
                                 e.id, result, zero, cyc, e.res, e.z, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (zero !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_when_idle: got zero=%b, want 0", zero);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        shamt_var = 1'b0;
        shamt     = 5'd0;
        rs        = 32'h0;
        rt        = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) check_rst_state("reset_idle");
        mon_en = 1;

        drive(2'b00, 1'b0, 5'd31, 32'h0, 32'h0000_0001, 32'h8000_0000, 1'b1);
        drive(2'b10, 1'b0, 5'd4, 32'h0, 32'h8000_0000, 32'h0800_0000, 1'b1);
        drive(2'b11, 1'b0, 5'd4, 32'h0, 32'h8000_0000, 32'hF800_0000, 1'b1);
        drive(2'b11, 1'b1, 5'd0, 32'hFFFF_FFE8, 32'h7F00_FF00, 32'h007F_00FF, 1'b1);
        drive(2'b01, 1'b0, 5'd12, 32'h0, 32'h1234_5678, 32'h6781_2345, 1'b1);
        drive(2'b10, 1'b0, 5'd1, 32'h0, 32'h0000_0001, 32'h0000_0000, 1'b1);
        idle(2);
        drive(2'b11, 1'b0, 5'd31, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
        drive(2'b11, 1'b0, 5'd31, 32'h0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
        drive(2'b01, 1'b1, 5'd7, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        drive(2'b00, 1'b0, 5'd0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        drive(2'b10, 1'b1, 5'd3, 32'h0000_0000, 32'h8765_4321, 32'h8765_4321, 1'b1);
        idle(4);

        // Op captured by stage 1, then reset before it reaches the output.
        drive(2'b00, 1'b0, 5'd3, 32'h0, 32'h0000_0011, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) check_rst_state("after_midflight_reset");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                idle(1);
            end else begin
                logic [31:0] t;
                case ($urandom_range(3))
                    0:       t = 32'h0;
                    1:       t = 32'h8000_0000 >> $urandom_range(31);
                    default: t = $urandom;
                endcase
                issue_model(2'($urandom_range(3)), 1'($urandom_range(1)),
                            5'($urandom_range(31)), $urandom, t);
            end
        end
        idle(1);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding results, want 0", exp_q.size());
        end
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
